// File: rtl/bus_responder_pkg.sv
// Shared definitions for the bus responder: address map, access sizes,
// peripheral register offsets and byte-lane helpers.
package bus_responder_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] PERIPH_BASE = 32'hFFFF_0000;

    localparam logic [4:0] OFF_MSIP        = 5'h00;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] OFF_MTIME_LO    = 5'h10;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h14;

    localparam logic [31:0] MSIP_ADDR        = PERIPH_BASE | 32'(OFF_MSIP);
    localparam logic [31:0] MTIMECMP_LO_ADDR = PERIPH_BASE | 32'(OFF_MTIMECMP_LO);
    localparam logic [31:0] MTIMECMP_HI_ADDR = PERIPH_BASE | 32'(OFF_MTIMECMP_HI);
    localparam logic [31:0] MTIME_LO_ADDR    = PERIPH_BASE | 32'(OFF_MTIME_LO);
    localparam logic [31:0] MTIME_HI_ADDR    = PERIPH_BASE | 32'(OFF_MTIME_HI);

    // An all-zero mask means the access is misaligned and must be dropped.
    function automatic logic [3:0] lane_mask(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] m;
        m = 4'b0000;
        unique case (size)
            SIZE_BYTE: m = 4'b0001 << off;
            SIZE_HALF: begin
                if (!off[0]) m = off[1] ? 4'b1100 : 4'b0011;
            end
            SIZE_WORD: begin
                if (off == 2'b00) m = 4'b1111;
            end
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicate right-justified write data across every lane it may target.
    function automatic logic [31:0] lane_data(
        input logic [1:0]  size,
        input logic [31:0] d
    );
        logic [31:0] r;
        unique case (size)
            SIZE_BYTE: r = {4{d[7:0]}};
            SIZE_HALF: r = {2{d[15:0]}};
            default:   r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bus_responder_if.sv
// CPU-side memory bus: address, write data, size, strobes and read data.
interface bus_responder_if;

    logic [31:0] address_bus;
    logic [31:0] data_bus_out;
    logic [1:0]  data_size;
    logic        write;
    logic        read;
    logic [31:0] data_bus_in;

    modport master (
        output address_bus,
        output data_bus_out,
        output data_size,
        output write,
        output read,
        input  data_bus_in
    );

    modport slave (
        input  address_bus,
        input  data_bus_out,
        input  data_size,
        input  write,
        input  read,
        output data_bus_in
    );

endinterface

// File: rtl/bus_responder_machine_timer.sv
// Machine timer: prescaled 64-bit mtime, 64-bit mtimecmp and the
// registered compare that drives the timer interrupt.
module machine_timer #(
    parameter int TIMER_PRESCALE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] wdata_i,
    input  logic        we_cmp_lo_i,
    input  logic        we_cmp_hi_i,
    input  logic        we_time_lo_i,
    input  logic        we_time_hi_i,
    output logic [63:0] mtime_o,
    output logic [63:0] mtimecmp_o,
    output logic        irq_o
);

    localparam logic [15:0] PS_LAST = 16'(TIMER_PRESCALE - 1);

    logic [15:0] ps_q, ps_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic        irq_q, irq_d;
    logic        tick;

    always_comb begin
        tick = (ps_q == PS_LAST);
        ps_d = tick ? 16'd0 : ps_q + 16'd1;

        mtime_d = mtime_q;
        // A CPU write owns this cycle: no increment, no carry between halves.
        if (we_time_lo_i || we_time_hi_i) begin
            if (we_time_lo_i) mtime_d[31:0]  = wdata_i;
            if (we_time_hi_i) mtime_d[63:32] = wdata_i;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        cmp_d = cmp_q;
        if (we_cmp_lo_i) cmp_d[31:0]  = wdata_i;
        if (we_cmp_hi_i) cmp_d[63:32] = wdata_i;

        irq_d = (mtime_q >= cmp_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ps_q    <= 16'd0;
            mtime_q <= 64'd0;
            cmp_q   <= '1;
            irq_q   <= 1'b0;
        end else begin
            ps_q    <= ps_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            irq_q   <= irq_d;
        end
    end

    assign mtime_o    = mtime_q;
    assign mtimecmp_o = cmp_q;
    assign irq_o      = irq_q;

endmodule

// File: rtl/bus_responder.sv
// Memory-mapped responder: byte-lane RAM at address 0 plus the msip and
// machine-timer registers in the 0xFFFF_0000 peripheral page.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int RAM_WORDS      = 1024,
    parameter int TIMER_PRESCALE = 1
) (
    input  logic           clock,
    input  logic           reset,
    bus_responder_if.slave bus,
    output logic           timer_interrupt,
    output logic           software_interrupt
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic [29:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic [4:0]    periph_off;
    logic          is_ram;
    logic          is_periph;

    assign word_addr  = bus.address_bus[31:2];
    assign ram_idx    = word_addr[AW-1:0];
    assign periph_off = {bus.address_bus[4:2], 2'b00};
    assign is_ram     = (word_addr < 30'(RAM_WORDS));
    assign is_periph  = (bus.address_bus[31:5] == PERIPH_BASE[31:5]);

    logic [3:0]  ram_mask;
    logic [31:0] ram_wdata;
    logic        ram_we;

    assign ram_mask  = lane_mask(bus.data_size, bus.address_bus[1:0]);
    assign ram_wdata = lane_data(bus.data_size, bus.data_bus_out);
    assign ram_we    = bus.write && is_ram && (ram_mask != 4'b0000);

    logic [31:0] mem_q [RAM_WORDS];

    always_ff @(posedge clock) begin
        if (ram_we) begin
            for (int l = 0; l < 4; l++) begin
                if (ram_mask[l]) begin
                    mem_q[ram_idx][8*l +: 8] <= ram_wdata[8*l +: 8];
                end
            end
        end
    end

    // Peripherals only take aligned full-word writes.
    logic periph_we;
    logic we_msip;
    logic we_cmp_lo;
    logic we_cmp_hi;
    logic we_time_lo;
    logic we_time_hi;

    assign periph_we  = bus.write && is_periph &&
                        (bus.data_size == SIZE_WORD) &&
                        (bus.address_bus[1:0] == 2'b00);
    assign we_msip    = periph_we && (periph_off == OFF_MSIP);
    assign we_cmp_lo  = periph_we && (periph_off == OFF_MTIMECMP_LO);
    assign we_cmp_hi  = periph_we && (periph_off == OFF_MTIMECMP_HI);
    assign we_time_lo = periph_we && (periph_off == OFF_MTIME_LO);
    assign we_time_hi = periph_we && (periph_off == OFF_MTIME_HI);

    logic msip_q, msip_d;

    assign msip_d = we_msip ? bus.data_bus_out[0] : msip_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            msip_q <= 1'b0;
        end else begin
            msip_q <= msip_d;
        end
    end

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        timer_irq;

    machine_timer #(
        .TIMER_PRESCALE (TIMER_PRESCALE)
    ) u_timer (
        .clock        (clock),
        .reset        (reset),
        .wdata_i      (bus.data_bus_out),
        .we_cmp_lo_i  (we_cmp_lo),
        .we_cmp_hi_i  (we_cmp_hi),
        .we_time_lo_i (we_time_lo),
        .we_time_hi_i (we_time_hi),
        .mtime_o      (mtime),
        .mtimecmp_o   (mtimecmp),
        .irq_o        (timer_irq)
    );

    logic [31:0] rd_data;

    always_comb begin
        rd_data = 32'd0;
        if (bus.read) begin
            if (is_ram) begin
                rd_data = mem_q[ram_idx];
            end else if (is_periph) begin
                unique case (periph_off)
                    OFF_MSIP:        rd_data = {31'd0, msip_q};
                    OFF_MTIMECMP_LO: rd_data = mtimecmp[31:0];
                    OFF_MTIMECMP_HI: rd_data = mtimecmp[63:32];
                    OFF_MTIME_LO:    rd_data = mtime[31:0];
                    OFF_MTIME_HI:    rd_data = mtime[63:32];
                    default:         rd_data = 32'd0;
                endcase
            end
        end
    end

    assign bus.data_bus_in     = rd_data;
    assign timer_interrupt     = timer_irq;
    assign software_interrupt  = msip_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: expected values are queued as stimulus
// is driven and compared when the DUT output is sampled.
module tb_bus_responder;
    import bus_responder_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic timer_interrupt;
    logic software_interrupt;

    always #5 clock = ~clock;

    bus_responder_if bus ();

    bus_responder #(
        .RAM_WORDS      (1024),
        .TIMER_PRESCALE (1)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .bus                (bus),
        .timer_interrupt    (timer_interrupt),
        .software_interrupt (software_interrupt)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h with no expectation", obs);
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp,
                      input string tag);
        push(tag, exp);
        bus.address_bus = addr;
        bus.read        = 1'b1;
        #1;
        pop_cmp(bus.data_bus_in);
        bus.read = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [1:0] size);
        bus.address_bus  = addr;
        bus.data_bus_out = data;
        bus.data_size    = size;
        bus.write        = 1'b1;
        @(posedge clock);
        #1;
        bus.write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.address_bus  = '0;
        bus.data_bus_out = '0;
        bus.data_size    = SIZE_WORD;
        bus.write        = 1'b0;
        bus.read         = 1'b0;
        reset            = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Reset state
        push("rst_tirq", 32'd0);
        pop_cmp({31'd0, timer_interrupt});
        push("rst_sirq", 32'd0);
        pop_cmp({31'd0, software_interrupt});
        rd(MTIMECMP_LO_ADDR, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(MTIMECMP_HI_ADDR, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd(MTIME_LO_ADDR, 32'd0, "rst_mtime_lo");
        rd(MSIP_ADDR, 32'd0, "rst_msip");

        // Write while reset is held is discarded
        wr(MSIP_ADDR, 32'd1, SIZE_WORD);
        rd(MSIP_ADDR, 32'd0, "rst_write_dropped");

        // First increment one clock after release
        reset = 1'b0;
        rd(MTIME_LO_ADDR, 32'd0, "mtime_before_tick");
        @(posedge clock);
        #1;
        rd(MTIME_LO_ADDR, 32'd1, "mtime_first_tick");

        // RAM lanes
        wr(32'h4, 32'h1122_3344, SIZE_WORD);
        wr(32'h6, 32'h0000_00A5, SIZE_BYTE);
        rd(32'h4, 32'h11A5_3344, "ram_byte_lane2");

        wr(32'h0, 32'hCAFE_F00D, SIZE_WORD);
        wr(32'h3, 32'h0000_BEEF, SIZE_HALF);
        wr(32'h2, 32'h1234_5678, SIZE_WORD);
        wr(32'h1, 32'h0000_0099, SIZE_RSVD);
        rd(32'h0, 32'hCAFE_F00D, "ram_misaligned_dropped");

        wr(32'h2, 32'h0000_BEEF, SIZE_HALF);
        wr(32'h3, 32'h0000_0077, SIZE_BYTE);
        rd(32'h0, 32'h77EF_F00D, "ram_half_byte_upper");
        rd(32'h3, 32'h77EF_F00D, "ram_read_aligned_word");

        // read=0 forces zero
        bus.address_bus = 32'h4;
        push("read_low_zero", 32'd0);
        #1;
        pop_cmp(bus.data_bus_in);

        // Unmapped and unused offsets
        rd(32'h8000_0000, 32'd0, "unmapped_read");
        wr(32'h0000_1000, 32'hDEAD_BEEF, SIZE_WORD);
        rd(32'h0000_1000, 32'd0, "above_ram_read");
        rd(32'h0, 32'h77EF_F00D, "above_ram_no_alias");
        wr(32'hFFFF_0004, 32'hDEAD_BEEF, SIZE_WORD);
        rd(32'hFFFF_0004, 32'd0, "periph_unused_4");
        rd(32'hFFFF_0018, 32'd0, "periph_unused_18");

        // Read and write in the same cycle
        wr(32'h8, 32'h0BAD_F00D, SIZE_WORD);
        bus.address_bus  = 32'h8;
        bus.data_bus_out = 32'h600D_CAFE;
        bus.data_size    = SIZE_WORD;
        bus.read         = 1'b1;
        bus.write        = 1'b1;
        push("rw_pre_write", 32'h0BAD_F00D);
        #1;
        pop_cmp(bus.data_bus_in);
        push("rw_post_write", 32'h600D_CAFE);
        @(posedge clock);
        #1;
        bus.write = 1'b0;
        pop_cmp(bus.data_bus_in);
        bus.read = 1'b0;

        // msip
        push("msip_set", 32'd1);
        wr(MSIP_ADDR, 32'd1, SIZE_WORD);
        pop_cmp({31'd0, software_interrupt});
        rd(MSIP_ADDR, 32'd1, "msip_read");
        push("msip_byte_dropped", 32'd1);
        wr(MSIP_ADDR, 32'd0, SIZE_BYTE);
        pop_cmp({31'd0, software_interrupt});
        push("msip_clear", 32'd0);
        wr(MSIP_ADDR, 32'hFFFF_FFFE, SIZE_WORD);
        pop_cmp({31'd0, software_interrupt});

        // Timer compare: hi first, then restart mtime, then lo=10
        wr(MTIMECMP_HI_ADDR, 32'd0, SIZE_WORD);
        wr(MTIME_LO_ADDR, 32'd0, SIZE_WORD);
        push("tirq_n1", 32'd0);
        wr(MTIMECMP_LO_ADDR, 32'd10, SIZE_WORD);
        pop_cmp({31'd0, timer_interrupt});
        rd(MTIME_LO_ADDR, 32'd1, "mtime_n1");
        for (int n = 2; n <= 14; n++) begin
            push($sformatf("tirq_n%0d", n), (n >= 11) ? 32'd1 : 32'd0);
            @(posedge clock);
            #1;
            pop_cmp({31'd0, timer_interrupt});
            rd(MTIME_LO_ADDR, 32'(n), $sformatf("mtime_n%0d", n));
        end

        // Sub-word peripheral write dropped
        wr(MTIMECMP_LO_ADDR, 32'd3, SIZE_HALF);
        rd(MTIMECMP_LO_ADDR, 32'd10, "cmp_half_dropped");

        // 64-bit wrap
        wr(MTIME_LO_ADDR, 32'hFFFF_FFFF, SIZE_WORD);
        wr(MTIME_HI_ADDR, 32'hFFFF_FFFF, SIZE_WORD);
        rd(MTIME_LO_ADDR, 32'hFFFF_FFFF, "wrap_lo_held");
        rd(MTIME_HI_ADDR, 32'hFFFF_FFFF, "wrap_hi_set");
        push("wrap_tirq_c", 32'd1);
        @(posedge clock);
        #1;
        pop_cmp({31'd0, timer_interrupt});
        rd(MTIME_LO_ADDR, 32'd0, "wrap_lo_c");
        rd(MTIME_HI_ADDR, 32'd0, "wrap_hi_c");
        push("wrap_tirq_d", 32'd0);
        @(posedge clock);
        #1;
        pop_cmp({31'd0, timer_interrupt});
        rd(MTIME_LO_ADDR, 32'd1, "wrap_lo_d");
        rd(MTIME_HI_ADDR, 32'd0, "wrap_hi_d");

        // Async reset mid-count
        wr(MTIMECMP_LO_ADDR, 32'd5, SIZE_WORD);
        wr(MSIP_ADDR, 32'd1, SIZE_WORD);
        repeat (6) @(posedge clock);
        #1;
        push("pre_rst_tirq", 32'd1);
        pop_cmp({31'd0, timer_interrupt});
        push("pre_rst_sirq", 32'd1);
        pop_cmp({31'd0, software_interrupt});
        reset = 1'b1;
        push("async_rst_tirq", 32'd0);
        push("async_rst_sirq", 32'd0);
        #1;
        pop_cmp({31'd0, timer_interrupt});
        pop_cmp({31'd0, software_interrupt});
        rd(MTIMECMP_LO_ADDR, 32'hFFFF_FFFF, "async_rst_cmp_lo");
        rd(MTIMECMP_HI_ADDR, 32'hFFFF_FFFF, "async_rst_cmp_hi");
        rd(MTIME_LO_ADDR, 32'd0, "async_rst_mtime");
        rd(32'h4, 32'h11A5_3344, "ram_not_reset");
        push("rst_write_sirq", 32'd0);
        wr(MSIP_ADDR, 32'd1, SIZE_WORD);
        pop_cmp({31'd0, software_interrupt});
        reset = 1'b0;
        @(posedge clock);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter RAM_WORDS, default 1024, meaning the number of 32-bit RAM words mapped from address 0x0000_0000.
REQ-002 Parameter TIMER_PRESCALE, default 1, meaning the number of clocks per mtime increment (range 1..65535).
REQ-003 clock  input  1  single clock for all state; rising-edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 address_bus  input  32  byte address from the CPU.
REQ-006 data_bus_out  input  32  CPU write data, right-justified (byte in [7:0], half in [15:0]).
REQ-007 data_size  input  2  access size: 0 byte, 1 half, 2 word, 3 reserved.
REQ-008 write  input  1  write strobe, committed on the rising clock edge.
REQ-009 read  input  1  read strobe.
REQ-010 data_bus_in  output  32  read data to the CPU.
REQ-011 timer_interrupt  output  1  registered, high while mtime >= mtimecmp.
REQ-012 software_interrupt  output  1  equals msip[0].

Function
REQ-013 Address map: RAM at 0x0000_0000..RAM_WORDS*4-1; msip 0xFFFF_0000; mtimecmp_lo 0xFFFF_0008; mtimecmp_hi 0xFFFF_000C; mtime_lo 0xFFFF_0010; mtime_hi 0xFFFF_0014; everything else is unmapped.
REQ-014 Reads are combinational: while read=1, data_bus_in presents the full aligned word at address_bus[31:2]; the CPU extracts sub-words itself.
REQ-015 data_bus_in shall be 0 when read=0, on unmapped addresses, and at unused peripheral offsets.
REQ-016 RAM writes shall update only the lanes selected by data_size and address_bus[1:0]: byte goes to lane addr[1:0]; half goes to lanes addr[1]*2..+1; word goes to all lanes.
REQ-017 Misaligned writes shall be dropped with no state change: a half with addr[0]=1, a word with addr[1:0]!=0, or data_size=3.
REQ-018 Peripheral registers accept word writes only; sub-word peripheral writes shall be dropped.
REQ-019 When read and write are both asserted in the same cycle, data_bus_in shows the pre-write value and the write commits at the edge.
REQ-020 mtime is a 64-bit counter driven by a prescale counter; it increments by 1 every TIMER_PRESCALE clocks and wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-021 A CPU write to mtime_lo or mtime_hi replaces that half and suppresses the increment in that cycle; the other half is unchanged, and no carry is applied.
REQ-022 timer_interrupt shall be registered from (mtime >= mtimecmp), an unsigned 64-bit compare, giving one clock of latency after any change to mtime or mtimecmp.
REQ-023 msip holds bit 0 only; writes store data_bus_out[0] and reads return {31'b0, msip}.
REQ-024 Writes to unmapped addresses shall be ignored.

Reset
REQ-025 On reset: mtime=0, prescale counter=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, msip=0, timer_interrupt=0, software_interrupt=0.
REQ-026 RAM contents are not reset.
REQ-027 A reset asserted during a write cycle shall discard that write for the peripheral registers.
REQ-028 The first mtime increment occurs TIMER_PRESCALE clocks after reset deasserts.

Structure
REQ-029 A shared package holds the address-map constants, data_size encodings (SIZE_BYTE/HALF/WORD) and peripheral offsets.
REQ-030 The timer is a separate sub-module, machine_timer, covering mtime, mtimecmp, the prescaler and the compare register; it receives decoded write enables and data.
REQ-031 RAM is an inferred array with per-lane write enables and asynchronous read.

Verification
REQ-032 Byte write 0xA5 to 0x0000_0006, then a word read of 0x0000_0004 (prior 0x1122_3344) -> 0x11A5_3344.
REQ-033 Half write 0xBEEF to 0x0000_0003 -> RAM unchanged; word write to 0x0000_0002 -> RAM unchanged.
REQ-034 TIMER_PRESCALE=1, mtimecmp set to 10 (hi written first, then lo) -> timer_interrupt rises exactly one clock after mtime reaches 10.
REQ-035 Write mtime_lo=0xFFFF_FFFF and mtime_hi=0xFFFF_FFFF, then run 2 clocks -> mtime=0x1, with wrap and no stuck state.
REQ-036 Write msip=1 -> software_interrupt=1 on the next cycle; write 0 -> cleared; an unmapped read of 0x8000_0000 -> 0.
REQ-037 Assert reset mid-count with mtimecmp=5 -> all outputs are 0 immediately (asynchronous), and mtimecmp reads back all-ones.
